// File: rtl/btb_pkg.sv
// btb_pkg: shared types and sizing for the BTB update scheduler
package btb_pkg;
  localparam int BTB_UPD_DEPTH = 8;
  localparam int BTB_PC_W = 64;
  typedef struct packed {
    logic [BTB_PC_W-1:0] pc;
    logic [BTB_PC_W-1:0] target;
  } btb_upd_t;
endpackage

// File: rtl/btb_upd_match.sv
// btb_upd_match: DEPTH-way PC comparator returning a one-hot hit vector over live entries
module btb_upd_match
  import btb_pkg::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH,
  parameter int PC_W = BTB_PC_W
) (
  input  logic [PC_W-1:0]  pcs [DEPTH],
  input  logic [DEPTH-1:0] live,
  input  logic [PC_W-1:0]  pc,
  output logic [DEPTH-1:0] hit
);
  // an entry hits only while it is still live in the queue
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = live[i] && pcs[i] == pc;
  end
endmodule

// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler: circular FIFO of resolved branch targets drained onto two BTB write ports (BTB_UPD_MERGE_EN merges same-PC updates)
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int DEPTH = BTB_UPD_DEPTH,
  parameter int PC_W = BTB_PC_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [PC_W-1:0] upd1_pc,
  input  logic [PC_W-1:0] upd1_target,
  input  logic            upd1_valid,
  input  logic [PC_W-1:0] upd2_pc,
  input  logic [PC_W-1:0] upd2_target,
  input  logic            upd2_valid,
  output logic            upd_stall,
  input  logic            btb_busy,
  output logic [PC_W-1:0] pc_idx1,
  output logic [PC_W-1:0] target_pc1,
  output logic            target_pc1_valid,
  output logic [PC_W-1:0] pc_idx2,
  output logic [PC_W-1:0] target_pc2,
  output logic            target_pc2_valid,
  output logic            drop_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  btb_upd_t mem [DEPTH];
  logic [AW-1:0] head, tail, head1;
  logic [CW-1:0] count, deq, free;
  logic need1, need2, acc1, acc2;
  logic [PC_W-1:0] tgt1;
  assign head1 = head + AW'(1);
  // write ports show the two oldest entries, zeroed whenever that port is not writing
  always_comb begin
    target_pc1_valid = count >= CW'(1) && !btb_busy;
    target_pc2_valid = count >= CW'(2) && !btb_busy;
    pc_idx1 = target_pc1_valid ? mem[head].pc : '0;
    target_pc1 = target_pc1_valid ? mem[head].target : '0;
    pc_idx2 = target_pc2_valid ? mem[head1].pc : '0;
    target_pc2 = target_pc2_valid ? mem[head1].target : '0;
    deq = CW'(target_pc1_valid) + CW'(target_pc2_valid);
    free = CW'(DEPTH) - count + deq;
    upd_stall = count > CW'(DEPTH - 2);
  end
`ifdef BTB_UPD_MERGE_EN
  logic [PC_W-1:0] pcs [DEPTH];
  logic [DEPTH-1:0] live, hit1, hit2, mg1, mg2;
  logic same;
  // live = occupied and not being dequeued this cycle
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pcs[i] = mem[i].pc;
      live[i] = {1'b0, AW'(i) - head} >= deq && {1'b0, AW'(i) - head} < count;
    end
  end
  btb_upd_match #(.DEPTH(DEPTH), .PC_W(PC_W)) u_match1 (.pcs(pcs), .live(live), .pc(upd1_pc), .hit(hit1));
  btb_upd_match #(.DEPTH(DEPTH), .PC_W(PC_W)) u_match2 (.pcs(pcs), .live(live), .pc(upd2_pc), .hit(hit2));
  // a hit rewrites the existing entry; equal PCs on both ports collapse into upd1's slot with upd2's target
  always_comb begin
    same = upd1_valid && upd2_valid && upd1_pc == upd2_pc;
    need1 = upd1_valid && !(|hit1);
    need2 = upd2_valid && !(|hit2) && !same;
    tgt1 = same ? upd2_target : upd1_target;
    mg1 = upd1_valid ? hit1 : '0;
    mg2 = upd2_valid && !same ? hit2 : '0;
  end
`else
  // every valid update needs its own entry
  always_comb begin
    need1 = upd1_valid;
    need2 = upd2_valid;
    tgt1 = upd1_target;
  end
`endif
  // admit upd1 then upd2 into space left after this cycle's dequeue; flush discards silently
  always_comb begin
    acc1 = need1 && free != '0;
    acc2 = need2 && free > CW'(acc1);
    drop_pulse = !flush && ((need1 && !acc1) || (need2 && !acc2));
  end
  // pointers and occupancy
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(acc1) + AW'(acc2);
      count <= count - deq + CW'(acc1) + CW'(acc2);
    end
  // entry storage; contents are meaningless outside the head..tail window so no reset
  always_ff @(posedge clock)
    if (!flush && !reset) begin
      if (acc1) mem[tail] <= '{pc: upd1_pc, target: tgt1};
      if (acc2) mem[tail + AW'(acc1)] <= '{pc: upd2_pc, target: upd2_target};
`ifdef BTB_UPD_MERGE_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (mg1[i]) mem[i].target <= tgt1;
        if (mg2[i]) mem[i].target <= upd2_target;
      end
`endif
    end
endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler: randomized and directed bench against a queue-based reference model
module tb_btb_update_scheduler;
  localparam int DEPTH = 8;
  logic clock = 0, reset = 1, flush = 0, btb_busy = 0;
  logic [63:0] upd1_pc = 0, upd1_target = 0, upd2_pc = 0, upd2_target = 0;
  logic upd1_valid = 0, upd2_valid = 0;
  logic upd_stall, target_pc1_valid, target_pc2_valid, drop_pulse;
  logic [63:0] pc_idx1, target_pc1, pc_idx2, target_pc2;
  typedef struct { logic [63:0] pc; logic [63:0] tgt; } ent_t;
  ent_t q[$];
  int n_cmp = 0, n_err = 0;

  btb_update_scheduler dut (
    .clock(clock), .reset(reset), .flush(flush),
    .upd1_pc(upd1_pc), .upd1_target(upd1_target), .upd1_valid(upd1_valid),
    .upd2_pc(upd2_pc), .upd2_target(upd2_target), .upd2_valid(upd2_valid),
    .upd_stall(upd_stall), .btb_busy(btb_busy),
    .pc_idx1(pc_idx1), .target_pc1(target_pc1), .target_pc1_valid(target_pc1_valid),
    .pc_idx2(pc_idx2), .target_pc2(target_pc2), .target_pc2_valid(target_pc2_valid),
    .drop_pulse(drop_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_v1"}, 64'(target_pc1_valid), 0);
    check({tag, "_v2"}, 64'(target_pc2_valid), 0);
    check({tag, "_pc1"}, pc_idx1, 0);
    check({tag, "_t1"}, target_pc1, 0);
    check({tag, "_pc2"}, pc_idx2, 0);
    check({tag, "_t2"}, target_pc2, 0);
    check({tag, "_stall"}, 64'(upd_stall), 0);
    check({tag, "_drop"}, 64'(drop_pulse), 0);
  endtask

  task automatic enq(input logic [63:0] p, input logic [63:0] t, inout int free, inout bit drop);
`ifdef BTB_UPD_MERGE_EN
    foreach (q[i]) if (q[i].pc == p) begin
      q[i].tgt = t;
      return;
    end
`endif
    if (free > 0) begin
      q.push_back('{p, t});
      free--;
    end else drop = 1;
  endtask

  task automatic step(input bit b, input bit f, input bit u1, input logic [63:0] p1, input logic [63:0] t1,
                      input bit u2, input logic [63:0] p2, input logic [63:0] t2);
    int n, free;
    bit ev1, ev2, drop;
    btb_busy = b; flush = f;
    upd1_valid = u1; upd1_pc = p1; upd1_target = t1;
    upd2_valid = u2; upd2_pc = p2; upd2_target = t2;
    @(negedge clock);
    n = q.size();
    ev1 = n >= 1 && !b;
    ev2 = n >= 2 && !b;
    check("v1", 64'(target_pc1_valid), 64'(ev1));
    check("v2", 64'(target_pc2_valid), 64'(ev2));
    check("pc1", pc_idx1, ev1 ? q[0].pc : 64'h0);
    check("t1", target_pc1, ev1 ? q[0].tgt : 64'h0);
    check("pc2", pc_idx2, ev2 ? q[1].pc : 64'h0);
    check("t2", target_pc2, ev2 ? q[1].tgt : 64'h0);
    check("stall", 64'(upd_stall), 64'(n > DEPTH - 2));
    if (ev1) void'(q.pop_front());
    if (ev2) void'(q.pop_front());
    free = DEPTH - q.size();
    drop = 0;
    if (u1) enq(p1, t1, free, drop);
    if (u2) enq(p2, t2, free, drop);
    if (f) begin
      q.delete();
      drop = 0;
    end
    check("drop", 64'(drop_pulse), 64'(drop));
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_init");
    reset = 0;
    idle(1);
    // reset mid-stream with three queued entries
    step(1, 0, 1, 64'h200, 64'h1, 1, 64'h204, 64'h2);
    step(1, 0, 1, 64'h208, 64'h3, 0, 0, 0);
    btb_busy = 0; upd1_valid = 0; upd2_valid = 0;
    reset = 1;
    #2;
    check_zero("reset_mid");
    q.delete();
    @(posedge clock);
    #1;
    reset = 0;
    idle(2);
    // dual update, both appear next cycle and drain
    step(0, 0, 1, 64'h92, 64'h10, 1, 64'h96, 64'h2c);
    check("lat_pc1", pc_idx1, 64'h92);
    check("lat_t2", target_pc2, 64'h2c);
    idle(2);
    // fill under busy, overflow drop, then drain
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 64'h32 + 64'(i * 16), 64'h100 + 64'(i), 1, 64'h36 + 64'(i * 16), 64'h200 + 64'(i));
    step(1, 0, 1, 64'h72, 64'h300, 0, 0, 0);
    check("full_stall", 64'(upd_stall), 1);
    idle(5);
    // flush beats enqueue
    step(0, 1, 1, 64'h42, 64'h30, 0, 0, 0);
    idle(2);
    // same-PC update while the first is held by busy
    step(1, 0, 1, 64'h92, 64'h10, 0, 0, 0);
    step(1, 0, 1, 64'h92, 64'h80, 0, 0, 0);
    idle(3);
    // same-PC on both ports in one cycle
    step(1, 0, 1, 64'ha0, 64'h5, 1, 64'ha0, 64'h6);
    idle(3);
    // alternating single/dual with random busy, exercising wrap
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1), 0, 1, 64'h1000 + 64'(i * 8), 64'($urandom), i % 2 == 1, 64'h1004 + 64'(i * 8), 64'($urandom));
    idle(6);
    // fully random, small PC pool so duplicates and merges occur
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0,
           $urandom_range(0, 1), 64'h400 + 64'($urandom_range(0, 7) * 4), 64'($urandom),
           $urandom_range(0, 1), 64'h400 + 64'($urandom_range(0, 7) * 4), 64'($urandom));
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
